fpadd_system: RTL and testbench

FPADD_SYSTEM -- requirements
Module: fpadd_system

---
 rtl/fpadd_system.sv | 174 +++++++++++++++++
 tb/tb_fpadd_system.sv | 115 +++++++++++
 2 files changed

// File: rtl/fpadd_system.sv
// fpadd_system: steps an index through a ROM of single-precision operand
// pairs, adds each pair (truncating, subnormals flushed), and shows the top
// byte of the sum on eight LEDs and two active-low seven-segment digits.
module fpadd_system #(
    parameter int NUM = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] leds,
    output logic       an0,
    output logic       an1,
    output logic       a0,
    output logic       b0,
    output logic       c0,
    output logic       d0,
    output logic       e0,
    output logic       f0,
    output logic       g0,
    output logic       fp0,
    output logic       a1,
    output logic       b1,
    output logic       c1,
    output logic       d1,
    output logic       e1,
    output logic       f1,
    output logic       g1,
    output logic       fp1
);

    logic [3:0]  index_reg;
    logic [31:0] opa_reg;
    logic [31:0] opb_reg;
    logic [31:0] result_reg;
    logic [31:0] sum_next;
    logic [63:0] rom [0:15];

    // Operand pairs {A, B}; slots at or beyond NUM read as zero.
    function automatic logic [63:0] rom_entry(input int k);
        case (k)
            0:       return {32'h3F800000, 32'h40000000};
            1:       return {32'h40400000, 32'hC0400000};
            2:       return {32'h3FC00000, 32'h3FC00000};
            3:       return {32'h7F800000, 32'h3F800000};
            4:       return {32'h7F800000, 32'hFF800000};
            5:       return {32'h7F7FFFFF, 32'h7F7FFFFF};
            6:       return {32'hBF800000, 32'h3F000000};
            7:       return {32'h00000001, 32'h3F800000};
            8:       return {32'h41200000, 32'h3DCCCCCD};
            9:       return {32'h00000000, 32'h80000000};
            default: return 64'h0;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rom
            assign rom[gi] = (gi < NUM) ? rom_entry(gi) : 64'h0;
        end
    endgenerate

    // Three-stage pipeline: index -> operand pair (registered ROM read) -> sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_reg  <= 4'd0;
            opa_reg    <= 32'd0;
            opb_reg    <= 32'd0;
            result_reg <= 32'd0;
        end else begin
            index_reg  <= (index_reg == 4'(NUM - 1)) ? 4'd0 : index_reg + 4'd1;
            {opa_reg, opb_reg} <= rom[index_reg];
            result_reg <= sum_next;
        end
    end

    // Adder datapath. 27 extra bits below the hidden bit plus a sticky bit keep
    // the truncated difference exact when a far-smaller operand is subtracted.
    logic        sa, sb, sl, ss, swap, sticky;
    logic [7:0]  ea, eb, el, es, dexp;
    logic [22:0] fa, fb, fl, fs, frac;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [50:0] ml_ext, ms_ext, ms_sh, ms_al;
    logic [51:0] mag;
    logic [5:0]  lead;
    logic signed [9:0] exp_n;

    // Combinational single-precision add with special-case priority.
    always_comb begin
        sa     = opa_reg[31];
        ea     = opa_reg[30:23];
        fa     = opa_reg[22:0];
        sb     = opb_reg[31];
        eb     = opb_reg[30:23];
        fb     = opb_reg[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        swap   = {eb, fb} > {ea, fa};
        sl     = swap ? sb : sa;
        el     = swap ? eb : ea;
        fl     = swap ? fb : fa;
        ss     = swap ? sa : sb;
        es     = swap ? ea : eb;
        fs     = swap ? fa : fb;
        ml_ext = {1'b1, fl, 27'd0};
        ms_ext = {1'b1, fs, 27'd0};
        dexp   = el - es;
        ms_sh  = ms_ext >> dexp;
        sticky = ((ms_sh << dexp) != ms_ext);
        ms_al  = ms_sh | {50'd0, sticky};
        mag    = (sl == ss) ? ({1'b0, ml_ext} + {1'b0, ms_al})
                            : ({1'b0, ml_ext} - {1'b0, ms_al});
        lead   = 6'd0;
        for (int i = 0; i < 52; i++) begin
            if (mag[i]) lead = 6'(i);
        end
        exp_n  = $signed({2'b00, el}) + $signed({4'b0000, lead}) - 10'sd50;
        frac   = 23'((mag << (6'd51 - lead)) >> 28);

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            sum_next = 32'h7FC00000;
        else if (a_inf)
            sum_next = {sa, 8'hFF, 23'd0};
        else if (b_inf)
            sum_next = {sb, 8'hFF, 23'd0};
        else if (a_zero && b_zero)
            sum_next = 32'd0;
        else if (a_zero)
            sum_next = opb_reg;
        else if (b_zero)
            sum_next = opa_reg;
        else if (mag == 52'd0)
            sum_next = 32'd0;
        else if (exp_n >= 10'sd255)
            sum_next = {sl, 8'hFF, 23'd0};
        else if (exp_n <= 10'sd0)
            sum_next = 32'd0;
        else
            sum_next = {sl, exp_n[7:0], frac};
    end

    // Active-low hex glyph, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: return ~7'h3F;
            4'h1: return ~7'h06;
            4'h2: return ~7'h5B;
            4'h3: return ~7'h4F;
            4'h4: return ~7'h66;
            4'h5: return ~7'h6D;
            4'h6: return ~7'h7D;
            4'h7: return ~7'h07;
            4'h8: return ~7'h7F;
            4'h9: return ~7'h6F;
            4'hA: return ~7'h77;
            4'hB: return ~7'h7C;
            4'hC: return ~7'h39;
            4'hD: return ~7'h5E;
            4'hE: return ~7'h79;
            default: return ~7'h71;
        endcase
    endfunction

    assign leds = result_reg[31:24];
    assign an0  = 1'b0;
    assign an1  = 1'b0;
    assign fp0  = 1'b1;
    assign fp1  = 1'b1;
    assign {g0, f0, e0, d0, c0, b0, a0} = seg7(result_reg[27:24]);
    assign {g1, f1, e1, d1, c1, b1, a1} = seg7(result_reg[31:28]);

endmodule

// File: tb/tb_fpadd_system.sv
// Scoreboard bench for fpadd_system: random reset pattern, expected sums from
// the published operand/result table, monitor compares every cycle.
module tb_fpadd_system;
    localparam int NUM = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] leds;
    logic an0, an1, a0, b0, c0, d0, e0, f0, g0, fp0;
    logic a1, b1, c1, d1, e1, f1, g1, fp1;

    fpadd_system #(.NUM(NUM)) dut (
        .clk(clk), .rst(rst), .leds(leds), .an0(an0), .an1(an1),
        .a0(a0), .b0(b0), .c0(c0), .d0(d0), .e0(e0), .f0(f0), .g0(g0), .fp0(fp0),
        .a1(a1), .b1(b1), .c1(c1), .d1(d1), .e1(e1), .f1(f1), .g1(g1), .fp1(fp1)
    );

    always #5 clk = ~clk;

    // Expected sums straight from the operand table.
    logic [31:0] sums [0:NUM-1] = '{
        32'h40400000, 32'h00000000, 32'h40400000, 32'h7F800000, 32'h7FC00000,
        32'h7F800000, 32'hBF000000, 32'h3F800000, 32'h41219999, 32'h00000000
    };
    // Lit segments (active-high, {g,f,e,d,c,b,a}) of each hex glyph.
    logic [6:0] glyph [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [31:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit seen [0:NUM-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Model of what the display shows: entry fetched one edge, summed the next.
    int m_idx = 0;
    int m_op = -1;
    logic [31:0] m_res = 32'd0;

    task automatic step(input bit r);
        rst = r;
        @(posedge clk);
        if (r) begin
            m_idx = 0;
            m_op  = -1;
            m_res = 32'd0;
        end else begin
            m_res = (m_op < 0) ? 32'd0 : sums[m_op];
            if (m_op >= 0) seen[m_op] = 1'b1;
            m_op  = m_idx;
            m_idx = (m_idx + 1) % NUM;
        end
        exp_q.push_back(m_res);
        #1;
    endtask

    // Monitor: one transaction per cycle, compared against the queued expectation.
    initial begin
        logic [31:0] e;
        logic [6:0] s0, s1;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cyc++;
                s0 = {g0, f0, e0, d0, c0, b0, a0};
                s1 = {g1, f1, e1, d1, c1, b1, a1};
                $display("cycle %0d rst=%0b result=%h leds=%h expect=%h", cyc, rst, dut.result_reg, leds, e);
                chk("result", dut.result_reg, e);
                chk("leds", {24'd0, leds}, {24'd0, e[31:24]});
                chk("digit0", {25'd0, s0}, {25'd0, ~glyph[e[27:24]]});
                chk("digit1", {25'd0, s1}, {25'd0, ~glyph[e[31:28]]});
                chk("an_fp", {28'd0, an0, an1, fp0, fp1}, 32'h3);
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM; i++) seen[i] = 1'b0;
        step(1'b1);
        step(1'b1);
        // Clean run across two full wraps.
        for (int i = 0; i < 2 * NUM + 4; i++) step(1'b0);
        // Reset while entry 6 is being displayed, then rerun.
        while (m_res != sums[6]) step(1'b0);
        step(1'b1);
        for (int i = 0; i < NUM + 3; i++) step(1'b0);
        // Random reset pulses of random length.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                int len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < NUM; i++) chk($sformatf("entry%0d_seen", i), {31'd0, seen[i]}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
